sr_latch_driver: RTL
====================

# sr_latch_driver

Clocked controller that drives a gate-level NAND SR latch (active-low set/reset, S=R=0 forbidden) from a synchronous write request. It converts each request into a bounded active-low pulse on exactly one latch input, then reads back q/qb through a synchronizer to confirm the stored value. If the readback does not match, it retries a bounded number of times. It sits between clocked control logic and the asynchronous latch, making the latch usable as a verified, glitch-safe storage bit.

## Interface
- PULSE_CYCLES, 2: cycles the selected latch input is held low per attempt; must be ≥1.
- SETTLE_CYCLES, 3: cycles both latch inputs are held high before readback; must be ≥2, to cover the 2-flop synchronizer.
- MAX_RETRY, 2: extra attempts after a failed readback; total attempts = MAX_RETRY+1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  write request; sampled only in IDLE.
- d  in  1  value to store; captured together with req.
- q  in  1  latch output; asynchronous to clk.
- qb  in  1  latch complement output; asynchronous to clk.
- s_n  out  1  latch set input, active-low; registered.
- r_n  out  1  latch reset input, active-low; registered.
- busy  out  1  high while a write is in progress.
- done  out  1  one-cycle completion strobe.
- err  out  1  write failed verification; valid with done, held until the next accept.
- val  out  1  synchronized q; second flop of the synchronizer.

## Operation
- Reset values (asynchronous):
  - s_n=1, r_n=1, busy=0, done=0, err=0, val=0.
  - Synchronizer flops 0, retry count 0, state IDLE.
- q and qb each pass through a 2-flop synchronizer, giving q_s and qb_s; val=q_s.
- States: IDLE, PULSE, SETTLE, CHECK.
- IDLE:
  - If req=1, capture target=d, clear err, clear the retry count, load the pulse counter, go to PULSE.
  - If req=0, stay in IDLE.
- PULSE:
  - target=1 → s_n=0, r_n=1.
  - target=0 → r_n=0, s_n=1.
  - Stays PULSE_CYCLES cycles, then goes to SETTLE.
- SETTLE: s_n=r_n=1 for SETTLE_CYCLES cycles, then goes to CHECK.
- CHECK: one cycle, s_n=r_n=1.
  - Pass is q_s==target and qb_s==!target → go to IDLE with done=1, err=0.
  - On fail with retry count < MAX_RETRY: increment the count, go to PULSE.
  - On fail with retry count = MAX_RETRY: go to IDLE with done=1, err=1.
  - q_s==qb_s (invalid latch state) or X on either input counts as a fail.
- busy=1 in PULSE, SETTLE and CHECK; busy=0 in IDLE.
- Invariant: s_n and r_n are never 0 in the same cycle, including across reset and retries.
- Rewriting the value the latch already holds still performs a full pulse/verify.
- req while busy=1 is ignored. It is not queued.
- Reset mid-operation:
  - s_n and r_n return to 1 asynchronously with rst_n falling.
  - The latch keeps its last value; no done is issued for the aborted write.

## Timing
- Accept at clock edge k (IDLE, req=1):
  - From edge k: s_n or r_n low and busy=1, through edge k+PULSE_CYCLES.
  - First CHECK is the state after edge k+PULSE_CYCLES+SETTLE_CYCLES.
- Success on the first attempt: done=1 and busy=0 after edge k+PULSE_CYCLES+SETTLE_CYCLES+1, i.e. k+6 at defaults.
- Each retry adds PULSE_CYCLES+SETTLE_CYCLES+1 cycles.
- Worst case: done after edge k+(MAX_RETRY+1)(PULSE_CYCLES+SETTLE_CYCLES+1), i.e. k+18 at defaults.
- done is high for exactly one cycle, in IDLE. A req in that same cycle is accepted, so back-to-back writes repeat every P+S+2 cycles.
- Retry counter width is $clog2(MAX_RETRY+1), with a minimum of 1. Phase counter width covers max(PULSE_CYCLES, SETTLE_CYCLES).

## Test plan
The bench connects the DUT to a NAND SR latch model.
- Reset: assert rst_n=0 mid-sim → s_n=1, r_n=1, busy=0, done=0, err=0 immediately; after release, all outputs unchanged until a req arrives.
- Write 1: req=1, d=1 at edge k → s_n=0 after edges k..k+1, r_n stays 1; done=1 after edge k+6 with err=0; q=1, qb=0, val=1.
- Write 0 following it: req=1, d=0 → r_n low for 2 cycles, s_n stays 1; done at +6 with err=0; q=0, qb=1, val=0.
- Stuck fault: force q=0, qb=1, then write d=1 → three s_n pulses; done=1 with err=1 after edge k+18; busy=1 throughout.
- Reset mid-PULSE: rst_n falls during s_n=0 → s_n=1 in the same timestep; latch keeps its value; no done.
- Continuous req=1 with alternating d, monitored every cycle:
  - accepts exactly every 7 cycles;
  - req ignored while busy;
  - assertion that s_n|r_n==1 holds in every cycle.

Source files
------------

// File: rtl/sr_latch_driver_if.sv
// Bundle between the write controller and a NAND SR latch.
//   req, d   : write request and data from clocked control logic
//   q, qb    : latch outputs, asynchronous to the controller clock
//   s_n, r_n : active-low latch set/reset drives
//   busy     : write in progress
//   done     : one-cycle completion strobe
//   err      : last write failed verification (valid with done)
//   val      : synchronized latch value
// The slave modport is the controller view; master is the requester/latch side.
interface sr_latch_driver_if;
  logic req;
  logic d;
  logic q;
  logic qb;
  logic s_n;
  logic r_n;
  logic busy;
  logic done;
  logic err;
  logic val;

  modport master (
    output req, d, q, qb,
    input  s_n, r_n, busy, done, err, val
  );

  modport slave (
    input  req, d, q, qb,
    output s_n, r_n, busy, done, err, val
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Clocked controller for a gate-level NAND SR latch. Each accepted write
// request becomes a bounded active-low pulse on exactly one latch input,
// followed by a settle window and a synchronized readback of q/qb. A failed
// readback is retried up to MAX_RETRY times before reporting err with done.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   io_bus : sr_latch_driver_if.slave (req/d/q/qb in, s_n/r_n/busy/done/err/val out)
//
// Parameters:
//   PULSE_CYCLES  : cycles the selected latch input is held low (>= 1)
//   SETTLE_CYCLES : cycles both inputs are high before readback (>= 2)
//   MAX_RETRY     : extra attempts after a failed readback
module sr_latch_driver #(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned MAX_RETRY     = 2
) (
  input logic              clk,
  input logic              rst_n,
  sr_latch_driver_if.slave io_bus
);

  localparam int unsigned CntMax = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CntW-1:0]   PulseLoad  = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0]   SettleLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax   = RetryW'(MAX_RETRY);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPulse  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StCheck  = 2'd3;

  logic [1:0]        r_state;
  logic [CntW-1:0]   r_cnt;
  logic [RetryW-1:0] r_retry;
  logic              r_target;
  logic              r_s_n;
  logic              r_r_n;
  logic              r_done;
  logic              r_err;
  logic              r_q_meta;
  logic              r_q_sync;
  logic              r_qb_meta;
  logic              r_qb_sync;

  logic [1:0]        w_state_next;
  logic [CntW-1:0]   w_cnt_next;
  logic [RetryW-1:0] w_retry_next;
  logic              w_target_next;
  logic              w_s_n_next;
  logic              w_r_n_next;
  logic              w_done_next;
  logic              w_err_next;
  logic              w_pass;

  // Two-flop synchronizers for the asynchronous latch outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_meta  <= 1'b0;
      r_q_sync  <= 1'b0;
      r_qb_meta <= 1'b0;
      r_qb_sync <= 1'b0;
    end else begin
      r_q_meta  <= io_bus.q;
      r_q_sync  <= r_q_meta;
      r_qb_meta <= io_bus.qb;
      r_qb_sync <= r_qb_meta;
    end
  end

  // Equal q/qb (invalid latch state) fails; an X operand makes the compare
  // unknown, which the CHECK branch below treats as a fail.
  assign w_pass = (r_q_sync == r_target) && (r_qb_sync == ~r_target);

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_retry_next  = r_retry;
    w_target_next = r_target;
    w_err_next    = r_err;
    w_done_next   = 1'b0;

    case (r_state)
      StIdle: begin
        if (io_bus.req) begin
          w_target_next = io_bus.d;
          w_err_next    = 1'b0;
          w_retry_next  = '0;
          w_cnt_next    = PulseLoad;
          w_state_next  = StPulse;
        end
      end
      StPulse: begin
        if (r_cnt == '0) begin
          w_cnt_next   = SettleLoad;
          w_state_next = StSettle;
        end else begin
          w_cnt_next = r_cnt - CntW'(1);
        end
      end
      StSettle: begin
        if (r_cnt == '0) begin
          w_state_next = StCheck;
        end else begin
          w_cnt_next = r_cnt - CntW'(1);
        end
      end
      StCheck: begin
        if (w_pass) begin
          w_done_next  = 1'b1;
          w_state_next = StIdle;
        end else if (r_retry == RetryMax) begin
          w_done_next  = 1'b1;
          w_err_next   = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_retry_next = r_retry + RetryW'(1);
          w_cnt_next   = PulseLoad;
          w_state_next = StPulse;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    // Drives are decoded from the next state so the registered pulse starts
    // on the accepting edge. A single target bit selects the input, so both
    // can never be low together.
    w_s_n_next = ~((w_state_next == StPulse) && w_target_next);
    w_r_n_next = ~((w_state_next == StPulse) && ~w_target_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_retry  <= '0;
      r_target <= 1'b0;
      r_s_n    <= 1'b1;
      r_r_n    <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_retry  <= w_retry_next;
      r_target <= w_target_next;
      r_s_n    <= w_s_n_next;
      r_r_n    <= w_r_n_next;
      r_done   <= w_done_next;
      r_err    <= w_err_next;
    end
  end

  assign io_bus.s_n  = r_s_n;
  assign io_bus.r_n  = r_r_n;
  assign io_bus.busy = (r_state != StIdle);
  assign io_bus.done = r_done;
  assign io_bus.err  = r_err;
  assign io_bus.val  = r_q_sync;

endmodule
